log_tap_delay_line: RTL and testbench



---
 rtl/log_tap_delay_line.sv | 160 ++++++++++++++++
 tb/tb_log_tap_delay_line.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_tap_delay_line.sv
// log_tap_delay_line
//
// Purpose:
//   Front end for the log-domain dot product. Each accepted fixed-point
//   sample is turned into a Mitchell log2 magnitude, a sign and a nonzero
//   flag over two pipeline stages. The result is then pushed into a LEN-deep
//   tap delay line, and all taps are presented as packed buses. The block
//   also tracks how many taps hold real samples and pulses once for every
//   new regressor vector.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset (priority over clear)
//   clear        synchronous flush of pipeline, taps and fill count
//   in_valid     x_in is valid this cycle
//   x_in         two's complement sample, QP fractional bits
//   log_packed   tap k log word at [k*LOG_WIDTH +: LOG_WIDTH], tap 0 newest
//   sign_packed  bit k = sign of tap k (1 = negative)
//   valid_packed bit k = tap k is nonzero
//   vec_strobe   one-cycle pulse after the taps shift
//   taps_full    LEN samples have entered since the last reset/clear
module log_tap_delay_line #(
    parameter int WIDTH     = 16,
    parameter int QP        = 12,
    parameter int LEN       = 8,
    parameter int LOG_WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         x_in,
    output logic [LEN*LOG_WIDTH-1:0] log_packed,
    output logic [LEN-1:0]           sign_packed,
    output logic [LEN-1:0]           valid_packed,
    output logic                     vec_strobe,
    output logic                     taps_full
);

    localparam int MAG_W  = WIDTH - 1;
    localparam int LOG_QP = LOG_WIDTH - 5;
    localparam int INT_W  = LOG_WIDTH - LOG_QP;
    localparam int LP_W   = $clog2(MAG_W);
    localparam int WIDE_W = MAG_W + LOG_QP;
    localparam int CNT_W  = $clog2(LEN + 1);

    logic [MAG_W-1:0]     x_neg;
    logic [MAG_W-1:0]     mag_in;

    logic                 s1_valid;
    logic                 s1_sign;
    logic [MAG_W-1:0]     s1_mag;

    logic [LP_W-1:0]      lead_pos;
    logic [MAG_W-1:0]     below_lead;
    logic [WIDE_W-1:0]    frac_wide;
    logic [INT_W-1:0]     int_part;
    logic                 s1_nz;
    logic [LOG_WIDTH-1:0] log_next;

    logic                 s2_valid;
    logic                 s2_sign;
    logic                 s2_nz;
    logic [LOG_WIDTH-1:0] s2_log;

    logic [CNT_W-1:0]     fill_count;
    logic [CNT_W-1:0]     count_next;

    // Magnitude over WIDTH-1 bits. The most negative input has no positive
    // counterpart, so it is clamped to the largest representable magnitude.
    always_comb begin
        x_neg = ~x_in[MAG_W-1:0] + 1'b1;
        if (x_in == {1'b1, {MAG_W{1'b0}}})
            mag_in = {MAG_W{1'b1}};
        else if (x_in[WIDTH-1])
            mag_in = x_neg;
        else
            mag_in = x_in[MAG_W-1:0];
    end

    // Stage 1: capture sign and magnitude of each accepted sample.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= x_in[WIDTH-1];
                s1_mag  <= mag_in;
            end
        end
    end

    // Mitchell log2: the leading-one position is the integer part, and the
    // bits below it, left-aligned to LOG_QP bits, are the fraction. The
    // integer and fraction fields never overlap, so concatenation equals
    // the sum modulo 2^LOG_WIDTH.
    always_comb begin
        lead_pos = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if (s1_mag[i])
                lead_pos = LP_W'(i);
        end
        s1_nz      = |s1_mag;
        below_lead = s1_mag & ~({MAG_W{1'b1}} << lead_pos);
        frac_wide  = {{LOG_QP{1'b0}}, below_lead};
        if (int'(lead_pos) <= LOG_QP)
            frac_wide = frac_wide << (LOG_QP - int'(lead_pos));
        else
            frac_wide = frac_wide >> (int'(lead_pos) - LOG_QP);
        int_part = INT_W'(int'(lead_pos) - QP);
        log_next = {int_part, LOG_QP'(frac_wide)};
    end

    // Stage 2: register the log word. A zero sample becomes an all-zero
    // entry so the dot product sees it as an empty tap.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            s2_valid <= 1'b0;
            s2_log   <= '0;
            s2_sign  <= 1'b0;
            s2_nz    <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_log  <= s1_nz ? log_next : '0;
                s2_sign <= s1_nz & s1_sign;
                s2_nz   <= s1_nz;
            end
        end
    end

    assign count_next = (fill_count == CNT_W'(LEN)) ? fill_count
                                                    : fill_count + 1'b1;

    // Delay line: the packed buses are the tap registers themselves, so a
    // left shift moves tap k into tap k+1 and the new entry lands in tap 0.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            log_packed   <= '0;
            sign_packed  <= '0;
            valid_packed <= '0;
            vec_strobe   <= 1'b0;
            taps_full    <= 1'b0;
            fill_count   <= '0;
        end else begin
            vec_strobe <= s2_valid;
            if (s2_valid) begin
                log_packed   <= {log_packed[(LEN-1)*LOG_WIDTH-1:0], s2_log};
                sign_packed  <= {sign_packed[LEN-2:0], s2_sign};
                valid_packed <= {valid_packed[LEN-2:0], s2_nz};
                fill_count   <= count_next;
                taps_full    <= (count_next == CNT_W'(LEN));
            end
        end
    end

endmodule

// File: tb/tb_log_tap_delay_line.sv
// tb_log_tap_delay_line
//
// Purpose:
//   Self-checking bench for log_tap_delay_line. A behavioural model holds the
//   expected taps as plain arrays and a queue of samples in flight, each due
//   two edges after acceptance. A compare process checks every output on each
//   falling edge, and directed sequences pin conversion values, latency, fill,
//   gaps, clear and reset behaviour with literal expectations.
module tb_log_tap_delay_line;

    localparam int WIDTH     = 16;
    localparam int QP        = 12;
    localparam int LEN       = 8;
    localparam int LOG_WIDTH = 17;
    localparam int LOG_QP    = LOG_WIDTH - 5;
    localparam int PW        = LEN * LOG_WIDTH;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic             in_valid;
    logic [WIDTH-1:0] x_in;
    logic [PW-1:0]    log_packed;
    logic [LEN-1:0]   sign_packed;
    logic [LEN-1:0]   valid_packed;
    logic             vec_strobe;
    logic             taps_full;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    typedef struct {
        int               due;
        logic [WIDTH-1:0] x;
    } pend_t;

    pend_t                pending[$];
    int                   edge_cnt = 0;
    logic [LOG_WIDTH-1:0] exp_log [LEN];
    logic                 exp_sign[LEN];
    logic                 exp_nz  [LEN];
    logic                 exp_strobe;
    int                   exp_count;

    always #5 clk = ~clk;

    log_tap_delay_line #(
        .WIDTH    (WIDTH),
        .QP       (QP),
        .LEN      (LEN),
        .LOG_WIDTH(LOG_WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .in_valid    (in_valid),
        .x_in        (x_in),
        .log_packed  (log_packed),
        .sign_packed (sign_packed),
        .valid_packed(valid_packed),
        .vec_strobe  (vec_strobe),
        .taps_full   (taps_full)
    );

    // Reference conversion from the arithmetic definition: floor(log2 m) as
    // integer part plus the truncated linear fraction (m - 2^p) / 2^p.
    function automatic void ref_convert(input logic [WIDTH-1:0] x,
                                        output logic [LOG_WIDTH-1:0] lg,
                                        output logic sg,
                                        output logic nz);
        int m;
        int p;
        int frac;
        int val;
        if (x[WIDTH-1])
            m = (x == 16'h8000) ? 32767 : 65536 - int'(x);
        else
            m = int'(x);
        if (m == 0) begin
            lg = '0;
            sg = 1'b0;
            nz = 1'b0;
        end else begin
            p = 0;
            while ((1 << (p + 1)) <= m)
                p++;
            frac = ((m - (1 << p)) << LOG_QP) >> p;
            val  = (p - QP) * (1 << LOG_QP) + frac;
            lg   = LOG_WIDTH'(val);
            sg   = x[WIDTH-1];
            nz   = 1'b1;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [PW-1:0] actual,
                               input logic [PW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] x,
                                 input logic clr, input logic rst);
        @(negedge clk);
        in_valid = v;
        x_in     = x;
        clear    = clr;
        reset    = rst;
    endtask

    // Model: reset/clear wipe everything including samples in flight; a
    // sample accepted at edge e lands in tap 0 at edge e+2.
    always @(posedge clk) begin
        edge_cnt++;
        if (reset || clear) begin
            pending.delete();
            for (int k = 0; k < LEN; k++) begin
                exp_log[k]  = '0;
                exp_sign[k] = 1'b0;
                exp_nz[k]   = 1'b0;
            end
            exp_strobe = 1'b0;
            exp_count  = 0;
        end else begin
            exp_strobe = 1'b0;
            if (pending.size() > 0 && pending[0].due == edge_cnt) begin
                for (int k = LEN - 1; k > 0; k--) begin
                    exp_log[k]  = exp_log[k-1];
                    exp_sign[k] = exp_sign[k-1];
                    exp_nz[k]   = exp_nz[k-1];
                end
                ref_convert(pending[0].x, exp_log[0], exp_sign[0], exp_nz[0]);
                void'(pending.pop_front());
                exp_strobe = 1'b1;
                if (exp_count < LEN)
                    exp_count++;
            end
            if (in_valid)
                pending.push_back('{due: edge_cnt + 2, x: x_in});
        end
    end

    // Compare all outputs against the model on every falling edge.
    always @(negedge clk) begin
        logic [PW-1:0]  el;
        logic [LEN-1:0] es;
        logic [LEN-1:0] ev;
        if (check_en) begin
            for (int k = 0; k < LEN; k++) begin
                el[k*LOG_WIDTH +: LOG_WIDTH] = exp_log[k];
                es[k] = exp_sign[k];
                ev[k] = exp_nz[k];
            end
            checkOutput("model_log_packed", log_packed, el);
            checkOutput("model_sign_packed", PW'(sign_packed), PW'(es));
            checkOutput("model_valid_packed", PW'(valid_packed), PW'(ev));
            checkOutput("model_vec_strobe", PW'(vec_strobe), PW'(exp_strobe));
            checkOutput("model_taps_full", PW'(taps_full), PW'(exp_count == LEN));
        end
    end

    initial begin
        logic [WIDTH-1:0]     conv_x   [7];
        logic [LOG_WIDTH-1:0] conv_log [7];
        logic                 conv_sign[7];
        logic                 conv_nz  [7];
        logic [LOG_WIDTH-1:0] m_lg;
        logic                 m_sg;
        logic                 m_nz;
        logic [PW-1:0]        saved_log;
        logic [6:0]           lat_pat;
        logic [13:0]          strobe_pat;
        logic [13:0]          full_pat;
        int                   strobe_n;
        int                   full_at;
        int                   v;
        logic                 r_v;
        logic                 r_c;
        logic                 r_r;
        logic [WIDTH-1:0]     r_x;

        reset    = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        x_in     = '0;

        conv_x    = '{16'h1000, 16'h1800, 16'h2000, 16'h0001, 16'hF000, 16'h0000, 16'h8000};
        conv_log  = '{17'h00000, 17'h00800, 17'h01000, 17'h14000, 17'h00000, 17'h00000, 17'h02FFF};
        conv_sign = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        conv_nz   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Pin the reference model to hand-computed conversions.
        for (int i = 0; i < 7; i++) begin
            ref_convert(conv_x[i], m_lg, m_sg, m_nz);
            checkOutput("ref_log", PW'(m_lg), PW'(conv_log[i]));
            checkOutput("ref_sign", PW'(m_sg), PW'(conv_sign[i]));
            checkOutput("ref_nz", PW'(m_nz), PW'(conv_nz[i]));
        end

        repeat (2) @(negedge clk);
        check_en = 1'b1;
        checkOutput("reset_log", log_packed, '0);
        checkOutput("reset_strobe", PW'(vec_strobe), '0);
        checkOutput("reset_full", PW'(taps_full), '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        $display("[TB] conversion values");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, conv_x[i], 1'b0, 1'b0);
            repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0);
            checkOutput("conv_tap0_log", PW'(log_packed[LOG_WIDTH-1:0]), PW'(conv_log[i]));
            checkOutput("conv_tap0_sign", PW'(sign_packed[0]), PW'(conv_sign[i]));
            checkOutput("conv_tap0_valid", PW'(valid_packed[0]), PW'(conv_nz[i]));
            checkOutput("conv_strobe", PW'(vec_strobe), PW'(1'b1));
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
        end

        $display("[TB] latency");
        saved_log = log_packed;
        lat_pat   = '0;
        applyStimulus(1'b1, 16'h1000, 1'b0, 1'b0);
        for (int j = 1; j <= 6; j++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
            lat_pat[j] = vec_strobe;
            if (j < 3)
                checkOutput("latency_taps_hold", log_packed, saved_log);
        end
        checkOutput("latency_strobe_pattern", PW'(lat_pat), PW'(7'b0001000));

        $display("[TB] fill and shift");
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        strobe_pat = '0;
        full_pat   = '0;
        for (int i = 0; i < 14; i++) begin
            if (i < 10) begin
                v = 4096 << i;
                if (v > 32767)
                    v = 32767;
                applyStimulus(1'b1, WIDTH'(v), 1'b0, 1'b0);
            end else begin
                applyStimulus(1'b0, '0, 1'b0, 1'b0);
            end
            strobe_pat[i] = vec_strobe;
            full_pat[i]   = taps_full;
        end
        checkOutput("fill_strobe_pattern", PW'(strobe_pat), PW'(14'h1FF8));
        checkOutput("fill_full_pattern", PW'(full_pat), PW'(14'h3C00));
        checkOutput("fill_tap0_log", PW'(log_packed[LOG_WIDTH-1:0]), PW'(17'h02FFF));
        checkOutput("fill_tap7_log", PW'(log_packed[7*LOG_WIDTH +: LOG_WIDTH]), PW'(17'h02000));

        $display("[TB] gaps");
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        strobe_n = 0;
        applyStimulus(1'b1, 16'h1800, 1'b0, 1'b0);
        strobe_n += int'(vec_strobe);
        repeat (2) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
            strobe_n += int'(vec_strobe);
        end
        applyStimulus(1'b1, 16'hF000, 1'b0, 1'b0);
        strobe_n += int'(vec_strobe);
        repeat (4) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
            strobe_n += int'(vec_strobe);
        end
        checkOutput("gap_strobe_count", PW'(strobe_n), PW'(2));
        checkOutput("gap_tap1_log", PW'(log_packed[LOG_WIDTH +: LOG_WIDTH]), PW'(17'h00800));
        checkOutput("gap_tap0_log", PW'(log_packed[LOG_WIDTH-1:0]), PW'(17'h00000));
        checkOutput("gap_sign", PW'(sign_packed), PW'(8'b0000_0001));
        checkOutput("gap_valid", PW'(valid_packed), PW'(8'b0000_0011));

        $display("[TB] clear mid-flight");
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        repeat (8) applyStimulus(1'b1, 16'h1000, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("clear_pre_full", PW'(taps_full), PW'(1'b1));
        applyStimulus(1'b1, 16'h2000, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("clear_log_zero", log_packed, '0);
        checkOutput("clear_sign_zero", PW'(sign_packed), '0);
        checkOutput("clear_valid_zero", PW'(valid_packed), '0);
        checkOutput("clear_full_zero", PW'(taps_full), '0);
        checkOutput("clear_strobe_n2", PW'(vec_strobe), '0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("clear_strobe_n3", PW'(vec_strobe), '0);
        applyStimulus(1'b1, 16'h1000, 1'b1, 1'b0);
        strobe_n = 0;
        repeat (5) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
            strobe_n += int'(vec_strobe);
        end
        checkOutput("clear_coincide_strobes", PW'(strobe_n), '0);
        checkOutput("clear_coincide_valid", PW'(valid_packed), '0);

        $display("[TB] reset mid-stream");
        repeat (5) applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b1);
        applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        checkOutput("reset_mid_log", log_packed, '0);
        checkOutput("reset_mid_valid", PW'(valid_packed), '0);
        checkOutput("reset_mid_strobe", PW'(vec_strobe), '0);
        checkOutput("reset_mid_full", PW'(taps_full), '0);
        strobe_n = 0;
        full_at  = -1;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
            strobe_n += int'(vec_strobe);
            if (taps_full && full_at < 0)
                full_at = strobe_n;
        end
        checkOutput("reset_refill_full_at", PW'(full_at), PW'(LEN));

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            r_v = ($urandom_range(0, 99) < 70);
            r_c = ($urandom_range(0, 99) < 3);
            r_r = ($urandom_range(0, 99) < 1);
            case ($urandom_range(0, 9))
                0:       r_x = 16'h8000;
                1:       r_x = 16'h0000;
                2:       r_x = 16'h0001;
                3:       r_x = 16'hFFFF;
                default: r_x = WIDTH'($urandom);
            endcase
            applyStimulus(r_v, r_x, r_c, r_r);
        end
        repeat (5) applyStimulus(1'b0, '0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
